// File: rtl/mux_nx1_reg.sv
// Registered N:1 multiplexer with valid/ack capture, ready backpressure,
// direct-select or round-robin arbitration. Optional Y_PAR via MUX_NX1_PARITY_EN.
module mux_nx1_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [CHANNELS-1:0]       IV,
  output logic [CHANNELS-1:0]       ACK,
  input  logic [SEL_W-1:0]          S,
  input  logic                      MODE,
  output logic [WIDTH-1:0]          Y,
  output logic                      Y_VALID,
  input  logic                      Y_READY,
  output logic [SEL_W-1:0]          Y_CH,
  output logic                      SEL_ERR
`ifdef MUX_NX1_PARITY_EN
  ,
  output logic                      Y_PAR
`endif
);

  logic [SEL_W-1:0]          ptr;
  logic                      load;
  logic                      has_cand;
  logic [SEL_W-1:0]          cand;
  logic                      sel_oor;
  logic [CHANNELS-1:0]       ivsh;
  logic [CHANNELS*WIDTH-1:0] dsh;
  logic [WIDTH-1:0]          cand_data;
  int unsigned               idx;

  assign load    = !Y_VALID || Y_READY;
  assign sel_oor = !(32'(S) < CHANNELS);

  // Shift-based lookup keeps every index a constant bit select.
  always_comb begin
    has_cand = 1'b0;
    cand     = '0;
    idx      = 0;
    ivsh     = '0;
    if (!MODE) begin
      if (!sel_oor) begin
        ivsh = IV >> S;
        if (ivsh[0]) begin
          has_cand = 1'b1;
          cand     = S;
        end
      end
    end else begin
      for (int unsigned n = 1; n <= CHANNELS; n++) begin
        idx  = (32'(ptr) + n) % CHANNELS;
        ivsh = IV >> idx;
        if (!has_cand && ivsh[0]) begin
          has_cand = 1'b1;
          cand     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    dsh       = I >> (32'(cand) * WIDTH);
    cand_data = dsh[WIDTH-1:0];
  end

  assign ACK = (load && has_cand && !RESET) ? (CHANNELS'(1) << cand) : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Y       <= '0;
      Y_VALID <= 1'b0;
      Y_CH    <= '0;
      SEL_ERR <= 1'b0;
      ptr     <= SEL_W'(CHANNELS - 1);
`ifdef MUX_NX1_PARITY_EN
      Y_PAR   <= 1'b0;
`endif
    end else begin
      SEL_ERR <= load && !MODE && sel_oor;
      if (load) begin
        if (has_cand) begin
          Y       <= cand_data;
          Y_CH    <= cand;
          Y_VALID <= 1'b1;
`ifdef MUX_NX1_PARITY_EN
          Y_PAR   <= ^cand_data;
`endif
          if (MODE) ptr <= cand;
        end else begin
          Y_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed self-checking bench for mux_nx1_reg: a 4-channel instance for the
// main scenarios and a 3-channel instance for out-of-range select.
module tb_mux_nx1_reg;

  logic        clk;
  logic        rst;

  logic [31:0] i4;
  logic [3:0]  iv4, ack4;
  logic [1:0]  s4, ych4;
  logic        mode4, yv4, yr4, serr4;
  logic [7:0]  y4;

  logic [23:0] i3;
  logic [2:0]  iv3, ack3;
  logic [1:0]  s3, ych3;
  logic        mode3, yv3, yr3, serr3;
  logic [7:0]  y3;

`ifdef MUX_NX1_PARITY_EN
  logic        par4, par3;
`endif

  int total = 0;
  int bad   = 0;

  mux_nx1_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .CLK(clk), .RESET(rst), .I(i4), .IV(iv4), .ACK(ack4), .S(s4), .MODE(mode4),
    .Y(y4), .Y_VALID(yv4), .Y_READY(yr4), .Y_CH(ych4), .SEL_ERR(serr4)
`ifdef MUX_NX1_PARITY_EN
    , .Y_PAR(par4)
`endif
  );

  mux_nx1_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .CLK(clk), .RESET(rst), .I(i3), .IV(iv3), .ACK(ack3), .S(s3), .MODE(mode3),
    .Y(y3), .Y_VALID(yv3), .Y_READY(yr3), .Y_CH(ych3), .SEL_ERR(serr3)
`ifdef MUX_NX1_PARITY_EN
    , .Y_PAR(par3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #1;
    total++; if (y4 !== 8'd0)   begin bad++; $display("FAIL reset_y got=%0d exp=0", y4); end
    total++; if (yv4 !== 1'b0)  begin bad++; $display("FAIL reset_yv got=%b exp=0", yv4); end
    total++; if (ych4 !== 2'd0) begin bad++; $display("FAIL reset_ych got=%0d exp=0", ych4); end
    total++; if (serr4 !== 1'b0) begin bad++; $display("FAIL reset_serr got=%b exp=0", serr4); end
    @(negedge clk) rst = 1'b0;
    // load an item, then reset asynchronously mid-cycle
    @(negedge clk);
    mode4 = 1'b0; s4 = 2'd2; iv4 = 4'b1111; yr4 = 1'b0;
    i4 = {8'd40, 8'd30, 8'd20, 8'd10};
    @(posedge clk) #1;
    total++; if (yv4 !== 1'b1 || y4 !== 8'd30) begin bad++; $display("FAIL pre_reset_load got y=%0d v=%b exp y=30 v=1", y4, yv4); end
    #1 rst = 1'b1;
    #1;
    total++; if (y4 !== 8'd0)   begin bad++; $display("FAIL async_reset_y got=%0d exp=0", y4); end
    total++; if (yv4 !== 1'b0)  begin bad++; $display("FAIL async_reset_yv got=%b exp=0", yv4); end
    total++; if (ych4 !== 2'd0) begin bad++; $display("FAIL async_reset_ych got=%0d exp=0", ych4); end
    total++; if (ack4 !== 4'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack4); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_direct;
    @(negedge clk);
    yr4 = 1'b1; s4 = 2'd1;
    #1;
    total++; if (ack4 !== 4'b0010) begin bad++; $display("FAIL direct_ack1 got=%b exp=0010", ack4); end
    @(posedge clk) #1;
    total++; if (y4 !== 8'd20 || ych4 !== 2'd1 || yv4 !== 1'b1)
      begin bad++; $display("FAIL direct_y1 got y=%0d ch=%0d v=%b exp y=20 ch=1 v=1", y4, ych4, yv4); end
    @(negedge clk);
    s4 = 2'd3;
    #1;
    total++; if (ack4 !== 4'b1000) begin bad++; $display("FAIL direct_ack3 got=%b exp=1000", ack4); end
    @(posedge clk) #1;
    total++; if (y4 !== 8'd40 || ych4 !== 2'd3 || yv4 !== 1'b1)
      begin bad++; $display("FAIL direct_y3 got y=%0d ch=%0d v=%b exp y=40 ch=3 v=1", y4, ych4, yv4); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    s4 = 2'd1;
    @(posedge clk) #1;
    total++; if (y4 !== 8'd20) begin bad++; $display("FAIL bp_setup got=%0d exp=20", y4); end
    @(negedge clk);
    yr4 = 1'b0;
    i4[15:8] = 8'd99;
    for (int n = 0; n < 3; n++) begin
      #1;
      total++; if (ack4 !== 4'b0) begin bad++; $display("FAIL bp_ack cyc=%0d got=%b exp=0000", n, ack4); end
      @(posedge clk) #1;
      total++; if (y4 !== 8'd20 || yv4 !== 1'b1)
        begin bad++; $display("FAIL bp_hold cyc=%0d got y=%0d v=%b exp y=20 v=1", n, y4, yv4); end
      @(negedge clk);
    end
    yr4 = 1'b1;
    #1;
    total++; if (ack4 !== 4'b0010) begin bad++; $display("FAIL bp_release_ack got=%b exp=0010", ack4); end
    @(posedge clk) #1;
    total++; if (y4 !== 8'd99 || yv4 !== 1'b1)
      begin bad++; $display("FAIL bp_release got y=%0d v=%b exp y=99 v=1", y4, yv4); end
  endtask

  task automatic test_round_robin;
    logic [1:0] order [6];
    logic [7:0] data  [4];
    order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    data  = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    mode4 = 1'b1; iv4 = 4'b1011; yr4 = 1'b1;
    i4 = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int n = 0; n < 6; n++) begin
      #1;
      total++; if (ack4 !== (4'b0001 << order[n]))
        begin bad++; $display("FAIL rr_ack step=%0d got=%b exp_ch=%0d", n, ack4, order[n]); end
      @(posedge clk) #1;
      total++; if (ych4 !== order[n] || y4 !== data[order[n]] || yv4 !== 1'b1)
        begin bad++; $display("FAIL rr_grant step=%0d got ch=%0d y=%h v=%b exp ch=%0d y=%h v=1",
                              n, ych4, y4, yv4, order[n], data[order[n]]); end
      @(negedge clk);
    end
    iv4 = 4'b0000;
    #1;
    total++; if (ack4 !== 4'b0) begin bad++; $display("FAIL rr_idle_ack got=%b exp=0000", ack4); end
    @(posedge clk) #1;
    total++; if (yv4 !== 1'b0 || y4 !== 8'h44 || ych4 !== 2'd3)
      begin bad++; $display("FAIL rr_idle got v=%b y=%h ch=%0d exp v=0 y=44 ch=3", yv4, y4, ych4); end
  endtask

  task automatic test_sel_err;
    @(negedge clk);
    mode3 = 1'b0; s3 = 2'd0; iv3 = 3'b111; yr3 = 1'b1;
    i3 = {8'h07, 8'h05, 8'h03};
    @(posedge clk) #1;
    total++; if (y3 !== 8'h03 || yv3 !== 1'b1 || serr3 !== 1'b0)
      begin bad++; $display("FAIL oor_setup got y=%h v=%b err=%b exp y=03 v=1 err=0", y3, yv3, serr3); end
    @(negedge clk);
    s3 = 2'd3;
    #1;
    total++; if (ack3 !== 3'b0) begin bad++; $display("FAIL oor_ack got=%b exp=000", ack3); end
    @(posedge clk) #1;
    total++; if (serr3 !== 1'b1 || yv3 !== 1'b0 || y3 !== 8'h03)
      begin bad++; $display("FAIL oor_err got err=%b v=%b y=%h exp err=1 v=0 y=03", serr3, yv3, y3); end
    @(negedge clk);
    s3 = 2'd2;
    #1;
    total++; if (ack3 !== 3'b100) begin bad++; $display("FAIL oor_recover_ack got=%b exp=100", ack3); end
    @(posedge clk) #1;
    total++; if (serr3 !== 1'b0 || y3 !== 8'h07 || ych3 !== 2'd2 || yv3 !== 1'b1)
      begin bad++; $display("FAIL oor_recover got err=%b y=%h ch=%0d v=%b exp err=0 y=07 ch=2 v=1", serr3, y3, ych3, yv3); end
`ifdef MUX_NX1_PARITY_EN
    total++; if (par3 !== 1'b1) begin bad++; $display("FAIL parity_07 got=%b exp=1", par3); end
`endif
    @(negedge clk);
    mode3 = 1'b1; s3 = 2'd3;
    @(posedge clk) #1;
    total++; if (serr3 !== 1'b0 || ych3 !== 2'd0 || y3 !== 8'h03)
      begin bad++; $display("FAIL rr3_first got err=%b ch=%0d y=%h exp err=0 ch=0 y=03", serr3, ych3, y3); end
`ifdef MUX_NX1_PARITY_EN
    total++; if (par3 !== 1'b0) begin bad++; $display("FAIL parity_03 got=%b exp=0", par3); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    i4 = '0; iv4 = '0; s4 = '0; mode4 = 1'b0; yr4 = 1'b0;
    i3 = '0; iv3 = '0; s3 = '0; mode3 = 1'b0; yr3 = 1'b0;
    test_reset;
    test_direct;
    test_backpressure;
    test_round_robin;
    test_sel_err;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
